// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared opcode/function encodings and enums for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    typedef enum logic [2:0] {
        opADD   = 3'd0,
        opSUB   = 3'd1,
        opCEQ   = 3'd2,
        opCLT   = 3'd3,
        opLW    = 3'd4,
        opSW    = 3'd5,
        opSEI   = 3'd6,
        opOTYPE = 3'd7
    } op_mne_e;

    // FUNC field under opOTYPE; shift codes occupy 0..fnSRO
    localparam logic [2:0] fnSLX = 3'd0;
    localparam logic [2:0] fnSLF = 3'd1;
    localparam logic [2:0] fnSRX = 3'd2;
    localparam logic [2:0] fnSRF = 3'd3;
    localparam logic [2:0] fnSRO = 3'd4;
    localparam logic [2:0] fnB0  = 3'd5;
    localparam logic [2:0] fnB1  = 3'd6;
    localparam logic [2:0] fnMUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_alu_st_e;

    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_MUL = 2'd2
    } iter_mode_e;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'd0,
        FILL_FLAG  = 2'd1,
        FILL_CARRY = 2'd2
    } fill_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_iter.sv
// ============================================================================
// Module      : seq_alu_iter
// Description : Iterative one-bit-per-cycle shifter and (with ALU_MUL_EN)
//               shift-add multiplier. result/carry_out show the current step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  iter_mode_e    mode,
    input  fill_e         fill,
    input  logic          flag_in,
    input  logic          carry_in,
    input  logic [W-1:0]  a,
`ifdef ALU_MUL_EN
    input  logic [W-1:0]  b,
`endif
    input  logic [SW:0]   count,
    output logic [W-1:0]  result,
    output logic          carry_out,
    output logic          last
);

    localparam logic [SW:0] c_one = {{SW{1'b0}}, 1'b1};

    logic [W-1:0] r_acc;
    logic         r_carry;
    logic         r_flag;
    logic [SW:0]  r_cnt;
    iter_mode_e   r_mode;
    fill_e        r_fill;
    logic         w_fill_bit;

`ifdef ALU_MUL_EN
    logic [W-1:0] r_hi;
    logic [W-1:0] r_mcand;
    logic [W:0]   w_sum;
    logic [W-1:0] w_hi_next;

    // r_acc holds the multiplier and collects product low bits from the top
    assign w_sum     = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
    assign w_hi_next = w_sum[W:1];
`endif

    always_comb begin
        case (r_fill)
            FILL_FLAG:  w_fill_bit = r_flag;
            FILL_CARRY: w_fill_bit = r_carry;
            default:    w_fill_bit = 1'b0;
        endcase
    end

    always_comb begin
        result    = r_acc;
        carry_out = r_carry;
        case (r_mode)
            IT_SHL: begin
                result    = {r_acc[W-2:0], w_fill_bit};
                carry_out = r_acc[W-1];
            end
            IT_SHR: begin
                result    = {w_fill_bit, r_acc[W-1:1]};
                carry_out = r_acc[0];
            end
`ifdef ALU_MUL_EN
            IT_MUL: begin
                result    = {w_sum[0], r_acc[W-1:1]};
                carry_out = |w_hi_next;
            end
`endif
            default: ;
        endcase
    end

    assign last = (r_cnt == c_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_flag  <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= IT_SHL;
            r_fill  <= FILL_ZERO;
`ifdef ALU_MUL_EN
            r_hi    <= '0;
            r_mcand <= '0;
`endif
        end else if (load) begin
            r_carry <= carry_in;
            r_flag  <= flag_in;
            r_cnt   <= count;
            r_mode  <= mode;
            r_fill  <= fill;
`ifdef ALU_MUL_EN
            r_acc   <= (mode == IT_MUL) ? b : a;
            r_hi    <= '0;
            r_mcand <= a;
`else
            r_acc   <= a;
`endif
        end else if (r_cnt != '0) begin
            r_acc   <= result;
            r_carry <= carry_out;
            r_cnt   <= r_cnt - c_one;
`ifdef ALU_MUL_EN
            r_hi    <= w_hi_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Registered ALU with internal FLAG/OVERFLOW and START/BUSY/DONE
//               handshake. Optional multiplier enabled by macro ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [2:0]    func,
    input  logic [W-1:0]  inputa,
    input  logic [W-1:0]  inputb,
    input  logic          clr_flags,
    output logic [W-1:0]  out,
    output logic          flag,
    output logic          overflow,
    output logic          branch_en,
    output logic          busy,
    output logic          done
);

`ifdef ALU_MUL_EN
    localparam logic [SW:0] c_mul_count = (SW+1)'(W);
`endif

    seq_alu_st_e  r_state, w_next;
    logic [W-1:0] r_out, w_out;
    logic         r_flag, w_flag, r_ovf, w_ovf, r_br, w_br;
    logic         w_flag_base, w_ovf_base;
    logic [W:0]   w_add, w_sub;
    logic [SW-1:0] w_n;
    logic         w_load;
    iter_mode_e   w_mode;
    fill_e        w_fill;
    logic [SW:0]  w_count;
    logic [W-1:0] w_it_result;
    logic         w_it_carry, w_it_last;

    // A clear in FIN would clobber the op's own update, so it is masked there
    assign w_flag_base = (clr_flags && r_state != ST_FIN) ? 1'b0 : r_flag;
    assign w_ovf_base  = (clr_flags && r_state != ST_FIN) ? 1'b0 : r_ovf;
    assign w_add = {1'b0, inputa} + {1'b0, inputb}  + {{W{1'b0}}, w_ovf_base};
    assign w_sub = {1'b0, inputa} + {1'b0, ~inputb} + {{W{1'b0}}, ~w_ovf_base};
    assign w_n   = inputb[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_out   = r_out;
        w_flag  = w_flag_base;
        w_ovf   = w_ovf_base;
        w_br    = 1'b0;
        w_load  = 1'b0;
        w_mode  = IT_SHL;
        w_fill  = FILL_ZERO;
        w_count = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_FIN;
                    case (op)
                        opADD: begin w_out = w_add[W-1:0]; w_ovf = w_add[W]; end
                        opSUB: begin w_out = w_sub[W-1:0]; w_ovf = ~w_sub[W]; end
                        opCEQ: begin w_out = '0; w_ovf = 1'b0; w_flag = (inputa == inputb); end
                        opCLT: begin w_out = '0; w_ovf = 1'b0; w_flag = (inputa < inputb); end
                        opLW, opSW: w_out = inputb;
                        opSEI:      w_out = inputa;
                        default: begin
                            case (func)
                                fnSLX, fnSLF, fnSRX, fnSRF, fnSRO: begin
                                    w_mode  = (func == fnSLX || func == fnSLF) ? IT_SHL : IT_SHR;
                                    w_fill  = (func == fnSLF || func == fnSRF) ? FILL_FLAG :
                                              (func == fnSRO) ? FILL_CARRY : FILL_ZERO;
                                    w_count = {1'b0, w_n};
                                    if (w_n == '0) begin
                                        w_out = inputa;
                                    end else begin
                                        w_load = 1'b1;
                                        w_next = ST_RUN;
                                    end
                                end
                                fnB0: begin w_out = '0; w_br = ~w_flag_base; end
                                fnB1: begin w_out = '0; w_br = w_flag_base; end
`ifdef ALU_MUL_EN
                                fnMUL: begin
                                    w_mode  = IT_MUL;
                                    w_count = c_mul_count;
                                    w_load  = 1'b1;
                                    w_next  = ST_RUN;
                                end
`endif
                                default: begin w_out = '0; w_ovf = 1'b0; end
                            endcase
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (w_it_last) begin
                    w_next = ST_FIN;
                    w_out  = w_it_result;
                    w_ovf  = w_it_carry;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_flag <= 1'b0;
            r_ovf  <= 1'b0;
            r_br   <= 1'b0;
        end else begin
            r_out  <= w_out;
            r_flag <= w_flag;
            r_ovf  <= w_ovf;
            r_br   <= w_br;
        end
    end

    seq_alu_iter #(.W(W), .SW(SW)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .mode      (w_mode),
        .fill      (w_fill),
        .flag_in   (w_flag_base),
        .carry_in  (w_ovf_base),
        .a         (inputa),
`ifdef ALU_MUL_EN
        .b         (inputb),
`endif
        .count     (w_count),
        .result    (w_it_result),
        .carry_out (w_it_carry),
        .last      (w_it_last)
    );

    assign out       = r_out;
    assign flag      = r_flag;
    assign overflow  = r_ovf;
    assign branch_en = r_br;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = 3;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr_flags = 1'b0;
    logic [2:0]   op = 3'd0, func = 3'd0;
    logic [W-1:0] inputa = '0, inputb = '0;
    logic [W-1:0] out;
    logic         flag, overflow, branch_en, busy, done;

    seq_alu #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .func(func),
        .inputa(inputa), .inputb(inputb), .clr_flags(clr_flags),
        .out(out), .flag(flag), .overflow(overflow), .branch_en(branch_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int inj_at = 0;
    logic inj_start = 1'b0, inj_clr = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs as the rules define them, tracked per cycle
    logic [W-1:0]   m_out, p_out, t_v;
    logic           m_flag, m_ovf, m_br, m_done, p_ovf, t_c, t_ob, t_fb;
    int             m_left, t_n, t_lat, t_d;
    logic [W:0]     t_s;
    logic [2*W-1:0] t_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0; m_flag = 0; m_ovf = 0; m_br = 0; m_done = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_br = 0;
        end else begin
            if (clr_flags) begin m_flag = 0; m_ovf = 0; end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_out = p_out; m_ovf = p_ovf; m_done = 1; end
            end else if (start) begin
                t_lat = 1; p_out = '0; p_ovf = m_ovf;
                case (op)
                    opADD: begin
                        t_s = {1'b0, inputa} + {1'b0, inputb} + {{W{1'b0}}, m_ovf};
                        p_out = t_s[W-1:0]; p_ovf = t_s[W];
                    end
                    opSUB: begin
                        t_d = int'(inputa) - int'(inputb) - int'(m_ovf);
                        p_out = t_d[W-1:0]; p_ovf = (t_d < 0);
                    end
                    opCEQ: begin m_flag = (inputa == inputb); p_ovf = 0; end
                    opCLT: begin m_flag = (inputa < inputb);  p_ovf = 0; end
                    opLW, opSW: p_out = inputb;
                    opSEI:      p_out = inputa;
                    default: begin
                        if (func <= 3'd4) begin
                            t_n = int'(inputb) % W;
                            if (t_n == 0) p_out = inputa;
                            else begin
                                t_v = inputa; t_c = m_ovf;
                                for (int k = 0; k < t_n; k++) begin
                                    t_ob = (func <= 3'd1) ? t_v[W-1] : t_v[0];
                                    t_fb = (func == 3'd1 || func == 3'd3) ? m_flag :
                                           (func == 3'd4) ? t_c : 1'b0;
                                    t_v  = (func <= 3'd1) ? {t_v[W-2:0], t_fb} : {t_fb, t_v[W-1:1]};
                                    t_c  = t_ob;
                                end
                                p_out = t_v; p_ovf = t_c; t_lat = t_n + 1;
                            end
                        end else if (func == 3'd5) m_br = !m_flag;
                        else if (func == 3'd6) m_br = m_flag;
                        else begin
`ifdef ALU_MUL_EN
                            t_prod = {{W{1'b0}}, inputa} * {{W{1'b0}}, inputb};
                            p_out = t_prod[W-1:0]; p_ovf = |t_prod[2*W-1:W]; t_lat = W + 1;
`else
                            p_ovf = 0;
`endif
                        end
                    end
                endcase
                if (t_lat == 1) begin m_out = p_out; m_ovf = p_ovf; m_done = 1; end
                else m_left = t_lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_out",  int'(out),       int'(m_out));
            chk("cyc_flag", int'(flag),      int'(m_flag));
            chk("cyc_ovf",  int'(overflow),  int'(m_ovf));
            chk("cyc_br",   int'(branch_en), int'(m_br));
            chk("cyc_busy", int'(busy),      int'(m_left > 0));
            chk("cyc_done", int'(done),      int'(m_done));
        end
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic [2:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic clr,
                          input int lat, input logic [W-1:0] eo, input logic ef,
                          input logic eov, input logic ebr);
        int n = 0;
        @(negedge clk);
        op = o; func = f; inputa = a; inputb = b; clr_flags = clr; start = 1'b1;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0; clr_flags = 1'b0;
            inputa = W'($urandom); inputb = W'($urandom); func = 3'($urandom);
            if (n == inj_at) begin
                start = inj_start; clr_flags = inj_clr; op = opADD;
            end
        end while (!done && n < 40);
        chk({nm, "_lat"},  n, lat);
        chk({nm, "_out"},  int'(out), int'(eo));
        chk({nm, "_flag"}, int'(flag), int'(ef));
        chk({nm, "_ovf"},  int'(overflow), int'(eov));
        chk({nm, "_br"},   int'(branch_en), int'(ebr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt;
        repeat (2) @(negedge clk);
        chk("rst_out", int'(out), 0);       chk("rst_flag", int'(flag), 0);
        chk("rst_ovf", int'(overflow), 0);  chk("rst_br", int'(branch_en), 0);
        chk("rst_busy", int'(busy), 0);     chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op("add_ff",  opADD, 3'd0, 8'hFF, 8'h01, 0, 1, 8'h00, 0, 1, 0);
        run_op("add_cin", opADD, 3'd0, 8'hF0, 8'h20, 0, 1, 8'h11, 0, 1, 0);
        run_op("add_03",  opADD, 3'd0, 8'h01, 8'h01, 0, 1, 8'h03, 0, 0, 0);
        run_op("sub",     opSUB, 3'd0, 8'h05, 8'h07, 0, 1, 8'hFE, 0, 1, 0);
        run_op("slx3",    opOTYPE, fnSLX, 8'h81, 8'h03, 0, 4, 8'h08, 0, 0, 0);
        run_op("sro1",    opOTYPE, fnSRO, 8'h01, 8'h01, 0, 2, 8'h00, 0, 1, 0);
        run_op("sro2",    opOTYPE, fnSRO, 8'h01, 8'h02, 0, 3, 8'hC0, 0, 0, 0);
        run_op("clt",     opCLT, 3'd0, 8'h03, 8'h09, 0, 1, 8'h00, 1, 0, 0);
        run_op("srf2",    opOTYPE, fnSRF, 8'h00, 8'h02, 0, 3, 8'hC0, 1, 0, 0);
        run_op("b1",      opOTYPE, fnB1, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 1);
        run_op("b0",      opOTYPE, fnB0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        run_op("ceq_t",   opCEQ, 3'd0, 8'h05, 8'h05, 0, 1, 8'h00, 1, 0, 0);
        run_op("ceq_f",   opCEQ, 3'd0, 8'h05, 8'h06, 0, 1, 8'h00, 0, 0, 0);
        run_op("add_ov",  opADD, 3'd0, 8'hFF, 8'h01, 0, 1, 8'h00, 0, 1, 0);
        run_op("sh_zero", opOTYPE, fnSLX, 8'h5A, 8'h08, 0, 1, 8'h5A, 0, 1, 0);
        run_op("lw",      opLW,  3'd0, 8'h00, 8'h33, 0, 1, 8'h33, 0, 1, 0);
        run_op("sei",     opSEI, 3'd0, 8'h44, 8'h00, 0, 1, 8'h44, 0, 1, 0);
        run_op("sw",      opSW,  3'd0, 8'h12, 8'h77, 0, 1, 8'h77, 0, 1, 0);
        run_op("add_clr", opADD, 3'd0, 8'h10, 8'h10, 1, 1, 8'h20, 0, 0, 0);
        run_op("ceq_s",   opCEQ, 3'd0, 8'h09, 8'h09, 0, 1, 8'h00, 1, 0, 0);

        inj_at = 2; inj_start = 1'b1; inj_clr = 1'b0;
        run_op("busy_start", opOTYPE, fnSLX, 8'h01, 8'h05, 0, 6, 8'h20, 1, 0, 0);
        inj_start = 1'b0; inj_clr = 1'b1;
        run_op("run_clr",    opOTYPE, fnSLX, 8'h01, 8'h05, 0, 6, 8'h20, 0, 0, 0);
        inj_at = 0; inj_clr = 1'b0;

`ifdef ALU_MUL_EN
        run_op("mul",     opOTYPE, fnMUL, 8'h10, 8'h11, 0, 9, 8'h10, 0, 1, 0);
`else
        run_op("mul_off", opOTYPE, fnMUL, 8'h10, 8'h11, 0, 1, 8'h00, 0, 0, 0);
`endif
        // Still in the DONE cycle: this request must be dropped
        op = opADD; inputa = 8'h01; inputb = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fin_start_busy", int'(busy), 0);
        chk("fin_start_done", int'(done), 0);

        run_op("pre_rst", opADD, 3'd0, 8'h7F, 8'h01, 0, 1, 8'h80, 0, 0, 0);
        @(negedge clk);
        op = opOTYPE; func = fnSLX; inputa = 8'hFF; inputb = 8'h07; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(out), 0);       chk("arst_flag", int'(flag), 0);
        chk("arst_ovf", int'(overflow), 0);  chk("arst_br", int'(branch_en), 0);
        chk("arst_busy", int'(busy), 0);     chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no_done_after_rst", cnt, 0);
        run_op("post_rst", opADD, 3'd0, 8'h02, 8'h03, 0, 1, 8'h05, 0, 0, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU; successor to the combinational 8-bit datapath ALU.
- Holds FLAG and OVERFLOW (carry/borrow/shift-out) in internal registers; callers no longer loop them back externally.
- Adds multi-bit shifts (one bit per cycle) and an optional shift-add multiplier, behind a START/BUSY/DONE handshake.
- Sits between register-file read ports and the writeback mux; branch unit samples BRANCH_EN.

Parameters:
- W, 8, datapath width in bits (>=4, power of 2).
- SW, $clog2(W), shift-amount width taken from INPUTB[SW-1:0].

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  operation request; accepted only when BUSY=0.
- OP  in  3  opcode (definitions package).
- FUNC  in  3  function field, used when OP=opOTYPE.
- INPUTA  in  W  operand A.
- INPUTB  in  W  operand B / shift amount.
- CLR_FLAGS  in  1  synchronous clear of FLAG and OVERFLOW.
- OUT  out  W  registered result, held until the next DONE.
- FLAG  out  1  registered compare flag.
- OVERFLOW  out  1  registered carry/borrow/shift-out.
- BRANCH_EN  out  1  branch-taken, valid only in the DONE cycle.
- BUSY  out  1  multi-cycle operation in progress.
- DONE  out  1  one-cycle pulse; OUT, FLAG, OVERFLOW and BRANCH_EN are updated in this cycle.

Behaviour:
- Reset: OUT=0, FLAG=0, OVERFLOW=0, BRANCH_EN=0, BUSY=0, DONE=0, FSM=IDLE. Reset mid-RUN aborts the operation with no DONE.
- FSM states: IDLE, RUN, FIN.
  - IDLE→FIN on START with a single-cycle op, or a shift with amount 0.
  - IDLE→RUN on START with a shift amount >0 or opMUL.
  - RUN→FIN when the iteration counter reaches its terminal value.
  - FIN→IDLE unconditionally; DONE=1 in FIN.
- Operands, OP, FUNC, and FLAG/OVERFLOW as carry-in are latched at accept. Later input changes have no effect.
- Latency:
  - single-cycle ops: DONE 1 cycle after START.
  - shift by n: DONE n+1 cycles after START.
  - opMUL: DONE W+1 cycles after START.
- START while BUSY=1 or in FIN: ignored, not queued. START in the same cycle DONE=1 is ignored; the next accept is in IDLE.
- Arithmetic, all W bits with a (W+1)-bit intermediate:
  - opADD: {OVERFLOW,OUT}=A+B+OVERFLOW.
  - opSUB: {OVERFLOW,OUT}=A+~B+1-OVERFLOW. Borrow is reported as OVERFLOW=~carry.
- Compare:
  - opCEQ: FLAG=(A==B).
  - opCLT: FLAG=(A<B), unsigned.
  - Both leave OUT=0 and OVERFLOW=0.
- Pass ops:
  - opLW/opSW: OUT=B.
  - opSEI: OUT=A.
  - FLAG and OVERFLOW unchanged.
- OTYPE shifts: n=B[SW-1:0]; one bit per RUN cycle. Fill bit:
  - _X: 0.
  - _F: latched FLAG.
  - _O: the running shift-out, rotate-through-carry.
  - OVERFLOW = last bit shifted out; n=0 gives OUT=A with OVERFLOW unchanged.
- fnB0/fnB1: OUT=0; BRANCH_EN=~FLAG or FLAG respectively, asserted only in the FIN cycle. BRANCH_EN=0 in all other cycles.
- Unused FUNC codes: OUT=0, OVERFLOW=0, FLAG held.
- CLR_FLAGS:
  - Clears FLAG and OVERFLOW in any state except FIN; in FIN the op's update wins.
  - Asserted with START, the clear applies before the carry-in is latched.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - FUNC=fnMUL under opOTYPE runs a W-cycle unsigned shift-add multiply.
  - OUT = low W bits of the product.
  - OVERFLOW=1 iff the high W bits are nonzero.
- Undefined: fnMUL decodes as an unused FUNC (single cycle, OUT=0), with no multiplier logic.

Decomposition:
- Shared definitions package gains:
  - opcode and FUNC constants, including fnMUL;
  - FSM state enum seq_alu_st_e;
  - op_mne enum for waveform view.
- One sub-module, seq_alu_iter: iterative shifter/multiplier datapath. It takes load, mode, operands and count, and returns result, carry-out and last.

Test Plan (W=8):
- opADD A=0xF0, B=0x20, OVERFLOW=1 → 1 cycle, OUT=0x11, OVERFLOW=1. Then opADD A=0x01, B=0x01 → OUT=0x03, OVERFLOW=0.
- opSUB A=0x05, B=0x07, OVERFLOW=0 → OUT=0xFE, OVERFLOW=1.
- Shift-left _X A=0x81, n=3 → BUSY 3 cycles, DONE at cycle 4, OUT=0x08, OVERFLOW=0.
- Shift-right _O A=0x01, n=1, OVERFLOW=0 → OUT=0x00, OVERFLOW=1.
- opCLT A=3, B=9 → FLAG=1. Then fnB1 → BRANCH_EN=1 for exactly one cycle. Then fnB0 → BRANCH_EN=0.
- Reset mid-shift (n=7, RST_N low at cycle 3) → all outputs 0 and no DONE. START during BUSY is ignored.
- ALU_MUL_EN: fnMUL 0x10×0x11 → DONE at cycle 9, OUT=0x10, OVERFLOW=1. With the macro undefined → OUT=0 after 1 cycle.
